// File: rtl/arbitro_memoria_dados.sv
// Two-port arbiter and access sequencer for the single-port 32-word data memory.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module arbitro_memoria_dados #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              ReadMem,
    output logic              WriteMem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                we_q, we_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [1:0]          ack_q, ack_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                winner;
    logic                weSel;

`ifdef ARB_ROUND_ROBIN_EN
    logic                ptr_q, ptr_d;

    // A tie goes to the port that did not win last; a lone request simply wins.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~ptr_q;
        end else begin
            winner = req1;
        end
    end
`else
    always_comb begin
        winner = 1'b0;
        if (!req0) begin
            winner = req1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            we_q    <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ack_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            read_q  <= read_d;
            write_q <= write_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Strobes and acks are single-cycle, so they default low every cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        ack_d   = 2'b00;
        weSel   = winner ? we1 : we0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d = winner;
                    we_d    = weSel;
                    addr_d  = winner ? addr1 : addr0;
                    wdata_d = winner ? wdata1 : wdata0;
                    read_d  = !weSel;
                    write_d = weSel;
                    state_d = ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = winner;
`endif
                end
            end
            ISSUE: begin
                ack_d[grant_q] = 1'b1;
                state_d        = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];
    assign rdata0    = (ack_q[0] && !we_q) ? mem_rdata : '0;
    assign rdata1    = (ack_q[1] && !we_q) ? mem_rdata : '0;
    assign busy      = (state_q != IDLE);
    assign ReadMem   = read_q;
    assign WriteMem  = write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Directed self-checking bench for arbitro_memoria_dados with a 32-word memory model.
// Expectations for contention follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_arbitro_memoria_dados;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst_n;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1, busy, ReadMem, WriteMem;
    logic [DATA_W-1:0] rdata0, rdata1, mem_wdata, memRdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] memArray [32];
    int                nChecks;
    int                nFails;

    arbitro_memoria_dados #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .ReadMem(ReadMem), .WriteMem(WriteMem),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(memRdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous memory: samples strobes on the edge closing ISSUE, read data valid afterwards.
    always @(posedge clk) begin
        if (WriteMem) memArray[mem_addr[4:0]] <= mem_wdata;
        if (ReadMem)  memRdata <= memArray[mem_addr[4:0]];
    end

    task automatic test_reset();
        @(negedge clk);
        nChecks++;
        if ({ReadMem, WriteMem, busy, ack0, ack1} !== 5'b00000) begin
            nFails++;
            $display("[TB] FAIL resetFlags: got %b expected %b", {ReadMem, WriteMem, busy, ack0, ack1}, 5'b00000);
        end
        nChecks++;
        if ({mem_addr, mem_wdata, rdata0, rdata1} !== 128'h0) begin
            nFails++;
            $display("[TB] FAIL resetData: got %h expected 0", {mem_addr, mem_wdata, rdata0, rdata1});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read_port0();
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 3;
        @(negedge clk);
        nChecks++;
        if ({ReadMem, WriteMem, busy, ack0, ack1} !== 5'b10100) begin
            nFails++;
            $display("[TB] FAIL readIssueFlags: got %b expected %b", {ReadMem, WriteMem, busy, ack0, ack1}, 5'b10100);
        end
        nChecks++;
        if (mem_addr !== 32'd3) begin
            nFails++;
            $display("[TB] FAIL readIssueAddr: got %0d expected 3", mem_addr);
        end
        @(negedge clk);
        nChecks++;
        if ({ReadMem, WriteMem, busy, ack0, ack1} !== 5'b00110) begin
            nFails++;
            $display("[TB] FAIL readRespFlags: got %b expected %b", {ReadMem, WriteMem, busy, ack0, ack1}, 5'b00110);
        end
        nChecks++;
        if (rdata0 !== 32'd4 || rdata1 !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL readRespData: got rdata0=%h rdata1=%h expected 4 and 0", rdata0, rdata1);
        end
        req0 = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({busy, ack0, rdata0} !== 34'h0) begin
            nFails++;
            $display("[TB] FAIL readDone: got busy=%b ack0=%b rdata0=%h expected all 0", busy, ack0, rdata0);
        end
    endtask

    task automatic test_write_read_port1();
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 5; wdata1 = 32'hDEADBEEF;
        @(negedge clk);
        nChecks++;
        if ({ReadMem, WriteMem, busy, ack0, ack1} !== 5'b01100) begin
            nFails++;
            $display("[TB] FAIL writeIssueFlags: got %b expected %b", {ReadMem, WriteMem, busy, ack0, ack1}, 5'b01100);
        end
        nChecks++;
        if (mem_addr !== 32'd5 || mem_wdata !== 32'hDEADBEEF) begin
            nFails++;
            $display("[TB] FAIL writeIssueBus: got addr=%0d data=%h expected 5 deadbeef", mem_addr, mem_wdata);
        end
        @(negedge clk);
        nChecks++;
        if ({ReadMem, WriteMem, busy, ack0, ack1} !== 5'b00101) begin
            nFails++;
            $display("[TB] FAIL writeRespFlags: got %b expected %b", {ReadMem, WriteMem, busy, ack0, ack1}, 5'b00101);
        end
        nChecks++;
        if (rdata1 !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL writeRespData: got %h expected 0", rdata1);
        end
        req1 = 1'b0;
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 5; wdata1 = 32'h0;
        @(negedge clk);
        @(negedge clk);
        nChecks++;
        if (ack1 !== 1'b1 || rdata1 !== 32'hDEADBEEF) begin
            nFails++;
            $display("[TB] FAIL readBack: got ack1=%b rdata1=%h expected 1 deadbeef", ack1, rdata1);
        end
        req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_protocol();
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 7;
        @(negedge clk);
        nChecks++;
        if (busy !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL protoBusyIssue: got %b expected 1", busy);
        end
        req0 = 1'b0; addr0 = 9;
        @(negedge clk);
        nChecks++;
        if ({busy, ack0} !== 2'b11 || rdata0 !== 32'd8) begin
            nFails++;
            $display("[TB] FAIL protoAck: got busy=%b ack0=%b rdata0=%h expected 1 1 8", busy, ack0, rdata0);
        end
        nChecks++;
        if (mem_addr !== 32'd7) begin
            nFails++;
            $display("[TB] FAIL protoLatchedAddr: got %0d expected 7", mem_addr);
        end
        @(negedge clk);
        nChecks++;
        if ({busy, ack0, ReadMem} !== 3'b000) begin
            nFails++;
            $display("[TB] FAIL protoIdle: got %b expected 000", {busy, ack0, ReadMem});
        end
    endtask

    task automatic test_contention();
        logic expAck0, expAck1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5;
        @(posedge clk);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
            expAck0 = (k == 1) || (k == 7);
            expAck1 = (k == 4);
`else
            expAck0 = (k % 3 == 1);
            expAck1 = 1'b0;
`endif
            nChecks++;
            if ({ack0, ack1} !== {expAck0, expAck1}) begin
                nFails++;
                $display("[TB] FAIL contendAck k=%0d: got %b expected %b", k, {ack0, ack1}, {expAck0, expAck1});
            end
            nChecks++;
            if (rdata0 !== (expAck0 ? 32'd4 : 32'd0) || rdata1 !== (expAck1 ? 32'hDEADBEEF : 32'd0)) begin
                nFails++;
                $display("[TB] FAIL contendData k=%0d: got rdata0=%h rdata1=%h", k, rdata0, rdata1);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        nChecks++;
        if (busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL contendIdle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 7; wdata0 = 32'h12345678;
        @(negedge clk);
        nChecks++;
        if (WriteMem !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL midWriteStrobe: got %b expected 1", WriteMem);
        end
        rst_n = 1'b0;
        #1;
        nChecks++;
        if ({ReadMem, WriteMem, busy, ack0, ack1} !== 5'b00000 || mem_addr !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL midWriteReset: got flags=%b addr=%0d expected 00000 0", {ReadMem, WriteMem, busy, ack0, ack1}, mem_addr);
        end
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            nChecks++;
            if ({busy, ack0, ack1} !== 3'b000) begin
                nFails++;
                $display("[TB] FAIL midWriteNoAck k=%0d: got %b expected 000", k, {busy, ack0, ack1});
            end
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 7;
        @(negedge clk);
        @(negedge clk);
        nChecks++;
        if (ack0 !== 1'b1 || rdata0 !== 32'd8) begin
            nFails++;
            $display("[TB] FAIL midWriteReadBack: got ack0=%b rdata0=%h expected 1 8", ack0, rdata0);
        end
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            nChecks++;
            if ({ReadMem, WriteMem, busy, ack0, ack1} !== 5'b00000 || mem_addr !== 32'd7) begin
                nFails++;
                $display("[TB] FAIL idle k=%0d: got flags=%b addr=%0d expected 00000 7", k, {ReadMem, WriteMem, busy, ack0, ack1}, mem_addr);
            end
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        for (int i = 0; i < 32; i++) memArray[i] = '0;
        memArray[3] = 32'd4;
        memArray[7] = 32'd8;
        memRdata = '0;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        test_reset();
        test_read_port0();
        test_write_read_port1();
        test_protocol();
        test_contention();
        test_reset_mid_write();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/arbitro_memoria_dados.md
# arbitro_memoria_dados

Two-port arbiter and access sequencer for the single-port 32-word data memory. It accepts load/store requests from two masters: port 0 is the processor MEM stage, port 1 is the secondary master (loader/debug/DMA). It grants one request at a time and drives the memory's ReadMem/WriteMem/address/write-data inputs for exactly one cycle. Each access ends with a single-cycle acknowledge carrying read data back to the winning master.

## Interface
Parameters:
- DATA_W, 32, data word width (memory word width)
- ADDR_W, 32, address width (word address; memory decodes low bits)

Ports:
- clk  in  1  rising-edge clock shared with the data memory
- rst_n  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read; held with req
- addr0 / addr1  in  ADDR_W  word address; held with req
- wdata0 / wdata1  in  DATA_W  write data; held with req
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  read data, valid only while ackN=1 for a read; 0 otherwise
- busy  out  1  1 whenever state ≠ IDLE
- ReadMem  out  1  memory read strobe (registered)
- WriteMem  out  1  memory write strobe (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_rdata  in  DATA_W  memory Exit_DataMem

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset → IDLE.
- IDLE, no req: stay. Any reqN=1 at edge: choose winner per arbitration rule.
  - Latch g (grant index) and weN.
  - Load mem_addr ← addrN, mem_wdata ← wdataN.
  - Set ReadMem ← !weN, WriteMem ← weN.
  - Go to ISSUE.
- ISSUE: memory performs the access at the closing edge. On that edge clear ReadMem/WriteMem, set ack_g ← 1, go to RESP.
- RESP: ack_g=1 for this one cycle. For reads, rdata_g = mem_rdata (combinational pass-through, valid since the ISSUE→RESP edge). For writes, rdata_g = 0. Next edge: ack_g ← 0, go to IDLE.
- Non-granted port: ack=0, rdata=0 throughout.
- Master protocol:
  - Hold req/we/addr/wdata stable until ack is seen.
  - Drop req at the edge ending the ack cycle.
  - A req still high in IDLE is a new request.
- Master drops req during ISSUE/RESP: the access still completes and ack still pulses.
- Arbitration (default, fixed priority): req0 beats req1 when both are high in IDLE.
- Only addr/data are latched; changes on inputs after the grant edge are ignored.
- Outputs at reset: ReadMem=0, WriteMem=0, mem_addr=0, mem_wdata=0, ack0=ack1=0, rdata0=rdata1=0, busy=0, state=IDLE, priority pointer=1.
- Reset mid-operation (asynchronous): all of the above is forced immediately.
  - Reset in ISSUE before the closing edge: WriteMem is already low at that edge, so no write occurs.
  - Memory contents are never cleared by this block.

## Timing
- Edge E0 (IDLE, reqN sampled): strobes and address registered high/valid during E0–E1.
- Edge E1: memory samples strobes; mem_rdata valid after E1; ackN high during E1–E2.
- Edge E2: ack low, back in IDLE. Earliest next grant at E3.
- Request-to-ack latency: 2 cycles. Sustained throughput: 1 access per 3 cycles.
- Competing request waiting during an access is granted at E3; maximum wait for a held request ≤ 6 cycles under round robin.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration using a 1-bit last-grant pointer, reset value 1 (port 0 wins the first tie).
  - On a tie, grant the port ≠ pointer.
  - The pointer updates to g on every grant, including uncontested grants.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins ties; the pointer is not implemented.

## Test plan
- Read, port 0: req0=1, we0=0, addr0=3 at E0 (memory preloaded mem[3]=4) → ReadMem=1 and mem_addr=3 during E0–E1; ack0=1 and rdata0=4 during E1–E2; ack1=0.
- Write then read, port 1: write addr1=5, wdata1=0xDEADBEEF → WriteMem pulses one cycle, ack1 pulses with rdata1=0. Then read addr1=5 → rdata1=0xDEADBEEF.
- Contention: req0 and req1 both held high from E0.
  - Default build: port 0 is served on every round (ack0 at E1, E4, E7; port 1 starved while req0 is held).
  - With ARB_ROUND_ROBIN_EN: acks alternate port 0, port 1, port 0 at E1, E4, E7.
- Protocol: req0 dropped at E0+1 (during ISSUE) → ack0 still pulses at E1–E2; FSM returns to IDLE at E2; busy high E0–E2.
- Reset mid-write: rst_n=0 during ISSUE of a write to addr 7 (old value 8) → WriteMem, ack and busy go low immediately; no ack pulse; a later read of addr 7 returns 8.
- Idle: no requests for 20 cycles → ReadMem=WriteMem=0, busy=0, acks 0, mem_addr unchanged.
